// File: rtl/ext_uart_tx.sv
// Byte-lane UART sink for the AXI-lite external write port (8N1).
// Define EXT_UART_TX_PARITY_EN to add an even-parity bit per frame.
module ext_uart_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int CLK_DIV    = 868
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ext_wr_req,
   input  logic [DATA_WIDTH-1:0] ext_wr_dat,
   input  logic [STRB_WIDTH-1:0] ext_wen,
   output logic                  ext_rsp_val,
   output logic                  uart_tx,
   output logic                  tx_busy
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      START,
      DATA,
`ifdef EXT_UART_TX_PARITY_EN
      PAR,
`endif
      STOP,
      RSP
   } state_t;

   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] word, word_n;
   logic [STRB_WIDTH-1:0] mask, mask_n, low;
   logic [7:0]            shift, shift_n, sel_byte;
   logic [CW-1:0]         cnt, cnt_n;
   logic [2:0]            idx, idx_n;
   logic                  tx_q, tx_n;
   logic                  bit_end;
`ifdef EXT_UART_TX_PARITY_EN
   logic                  par, par_n;
`endif

   assign bit_end = (cnt == CW'(CLK_DIV - 1));
   // Isolate the lowest pending lane as a one-hot vector.
   assign low = mask & (~mask + STRB_WIDTH'(1));

   always_comb begin
      sel_byte = 8'h00;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (low[i]) sel_byte = word[8*i +: 8];
      end
   end

   always_comb begin
      state_n = state;
      word_n  = word;
      mask_n  = mask;
      shift_n = shift;
      cnt_n   = '0;
      idx_n   = idx;
      tx_n    = tx_q;
`ifdef EXT_UART_TX_PARITY_EN
      par_n   = par;
`endif
      unique case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (ext_wr_req) begin
               word_n  = ext_wr_dat;
               mask_n  = ext_wen;
               state_n = SEL;
            end
         end
         SEL: begin
            tx_n = 1'b1;
            if (mask == '0) begin
               state_n = RSP;
            end else begin
               shift_n = sel_byte;
               mask_n  = mask & ~low;
               idx_n   = 3'd0;
               tx_n    = 1'b0;
               state_n = START;
`ifdef EXT_UART_TX_PARITY_EN
               par_n   = ^sel_byte;
`endif
            end
         end
         START: begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
            if (bit_end) begin
               tx_n    = shift[0];
               state_n = DATA;
            end
         end
         DATA: begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
            if (bit_end) begin
               shift_n = shift >> 1;
               idx_n   = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef EXT_UART_TX_PARITY_EN
                  tx_n    = par;
                  state_n = PAR;
`else
                  tx_n    = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  tx_n = shift[1];
               end
            end
         end
`ifdef EXT_UART_TX_PARITY_EN
         PAR: begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
            if (bit_end) begin
               tx_n    = 1'b1;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
            if (bit_end) begin
               tx_n    = 1'b1;
               state_n = SEL;
            end
         end
         RSP: begin
            tx_n    = 1'b1;
            state_n = IDLE;
         end
         default: begin
            tx_n    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         word  <= '0;
         mask  <= '0;
         shift <= '0;
         cnt   <= '0;
         idx   <= '0;
         tx_q  <= 1'b1;
`ifdef EXT_UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         word  <= word_n;
         mask  <= mask_n;
         shift <= shift_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         tx_q  <= tx_n;
`ifdef EXT_UART_TX_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   assign uart_tx     = tx_q;
   assign tx_busy     = (state != IDLE);
   assign ext_rsp_val = (state == RSP);

endmodule

// File: tb/tb_ext_uart_tx.sv
// Directed bench for ext_uart_tx with CLK_DIV=4 (8N1 build).
module tb_ext_uart_tx;

   localparam int DIV = 4;
   localparam int FB  = 10 * DIV + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] dat;
   logic [3:0]  wen;
   logic        rsp;
   logic        tx;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ext_uart_tx #(
      .DATA_WIDTH(32),
      .STRB_WIDTH(4),
      .CLK_DIV(DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ext_wr_req(req),
      .ext_wr_dat(dat),
      .ext_wen(wen),
      .ext_rsp_val(rsp),
      .uart_tx(tx),
      .tx_busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level c cycles after accept, frames packed in bytes[8j+:8].
   function automatic logic exp_tx(int c, logic [31:0] bytes, int nb);
      int t, j, off, b;
      t = c - 2;
      if (t < 0) return 1'b1;
      j   = t / FB;
      off = t % FB;
      if (j >= nb) return 1'b1;
      if (off == FB - 1) return 1'b1;
      b = off / DIV;
      if (b == 0) return 1'b0;
      if (b <= 8) return bytes[8*j + b - 1];
      return 1'b1;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"}, tx, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rsp"}, rsp, 0);
   endtask

   task automatic run_word(input bit pre, input logic [31:0] d,
                           input logic [3:0] w, input logic [31:0] bytes,
                           input int nb, input int rsp_at,
                           input string tag);
      if (pre) tick;
      req = 1'b1;
      dat = d;
      wen = w;
      for (int c = 1; c <= rsp_at; c++) begin
         tick;
         if (c == 1) begin
            dat = ~d;
            wen = ~w;
         end
         chk({tag, "_tx"}, tx, exp_tx(c, bytes, nb));
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_rsp"}, rsp, (c == rsp_at) ? 1 : 0);
         if (c == rsp_at) req = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0;
      dat = '0;
      wen = '0;
      tick;
      tick;
      chk_idle("reset");
      rst = 1'b0;
      tick;
      chk_idle("idle");
      tick;
      chk_idle("idle2");

      run_word(1, 32'h0000_0055, 4'b0001, 32'h0000_0055, 1, 43,
               "single");
      run_word(1, 32'h4433_2211, 4'b1111, 32'h4433_2211, 4, 166,
               "full");
      tick;
      chk_idle("after_full");
      run_word(1, 32'hDDCC_BBAA, 4'b1010, 32'h0000_DDBB, 2, 84,
               "sparse");
      run_word(1, 32'hA5A5_A5A5, 4'b0000, 32'h0, 0, 2, "empty");
      tick;
      chk_idle("after_empty");

      tick;
      req = 1'b1;
      dat = 32'h0000_0055;
      wen = 4'b0001;
      for (int c = 1; c <= 18; c++) begin
         tick;
         chk("pre_rst_tx", tx, exp_tx(c, 32'h55, 1));
      end
      rst = 1'b1;
      tick;
      chk_idle("mid_rst");
      rst = 1'b0;
      run_word(0, 32'h0000_0055, 4'b0001, 32'h0000_0055, 1, 43,
               "resend");
      tick;
      chk_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
